// File: rtl/seq_pattern_generator.sv
// Serial pattern transmitter: sends a latched parallel pattern MSB-first,
// repeated a programmable number of times with an optional idle gap between
// repetitions. All outputs are registered; x feeds a sequence detector directly.
//
// state  | meaning
// IDLE   | waiting for start; all outputs low
// SHIFT  | driving one pattern bit per cycle
// GAP    | idle cycles between repetitions, busy still high
// DONE   | single-cycle done pulse, then back to IDLE
module seq_pattern_generator #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] REP_ZERO = '0;
  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = '0;
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] reps_q;
  logic [GAP_W-1:0] gap_cfg_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             x_q;
  logic             x_valid_q;
  logic             frame_start_q;
  logic             busy_q;
  logic             done_q;

  logic [IDX_W-1:0] idx_d;

  // Index of the next bit to send while shifting within one repetition.
  always_comb begin
    idx_d = idx_q - IDX_ONE;
  end

  // Sequencer: state, shadow registers, counters and registered outputs.
  // Outputs are computed one edge ahead so they describe the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pat_q         <= '0;
      reps_q        <= '0;
      gap_cfg_q     <= '0;
      gap_cnt_q     <= '0;
      idx_q         <= '0;
      x_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // abort is deliberately not examined here: start always wins in IDLE
          if (start) begin
            pat_q     <= pattern;
            reps_q    <= repeat_cnt;
            gap_cfg_q <= gap_cycles;
            if (repeat_cnt == REP_ZERO) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q       <= S_SHIFT;
              idx_q         <= IDX_MSB;
              x_q           <= pattern[PAT_W-1];
              x_valid_q     <= 1'b1;
              frame_start_q <= 1'b1;
              busy_q        <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (abort) begin
            state_q       <= S_IDLE;
            x_q           <= 1'b0;
            x_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
          end else if (idx_q != IDX_ZERO) begin
            idx_q         <= idx_d;
            x_q           <= pat_q[idx_d];
            frame_start_q <= 1'b0;
          end else if (reps_q == REP_ONE) begin
            state_q       <= S_DONE;
            x_q           <= 1'b0;
            x_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end else begin
            reps_q <= reps_q - REP_ONE;
            if (gap_cfg_q == GAP_ZERO) begin
              idx_q         <= IDX_MSB;
              x_q           <= pat_q[PAT_W-1];
              frame_start_q <= 1'b1;
            end else begin
              state_q       <= S_GAP;
              gap_cnt_q     <= gap_cfg_q;
              x_q           <= 1'b0;
              x_valid_q     <= 1'b0;
              frame_start_q <= 1'b0;
            end
          end
        end

        S_GAP: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (gap_cnt_q == GAP_ONE) begin
            state_q       <= S_SHIFT;
            idx_q         <= IDX_MSB;
            x_q           <= pat_q[PAT_W-1];
            x_valid_q     <= 1'b1;
            frame_start_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_ONE;
          end
        end

        S_DONE: begin
          // start and abort are both ignored for this one cycle
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q       <= S_IDLE;
          x_q           <= 1'b0;
          x_valid_q     <= 1'b0;
          frame_start_q <= 1'b0;
          busy_q        <= 1'b0;
          done_q        <= 1'b0;
        end
      endcase
    end
  end

  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/seq_pattern_generator.md
Name: seq_pattern_generator

Overview:
Serial bit-pattern transmitter that drives a serial line from a parallel pattern. Each burst sends the pattern MSB-first, repeated a programmable number of times, with an optional idle gap between repetitions. It is the stimulus/transmit end for the team's serial Mealy sequence detectors, and its `x` output connects directly to a detector's `x` input.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
CNT_W, 8, width of repetition count
GAP_W, 4, width of inter-repetition gap count

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a burst; sampled only in IDLE
abort  input  1  synchronous abort of current burst
pattern  input  PAT_W  pattern to send, bit PAT_W-1 first
repeat_cnt  input  CNT_W  number of pattern repetitions (0 = none)
gap_cycles  input  GAP_W  idle cycles between repetitions (0 = back-to-back)
x  output  1  serial data bit
x_valid  output  1  x carries a pattern bit this cycle
frame_start  output  1  high with the first (MSB) bit of every repetition
busy  output  1  burst in progress (SHIFT or GAP)
done  output  1  one-cycle pulse at end of burst

Behaviour:
- All outputs are registered. Async reset (rst_n=0) forces state=IDLE and x, x_valid, frame_start, busy, done all to 0, plus all shadow registers and counters to 0.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: outputs 0. When start=1 at a rising edge, latch pattern, repeat_cnt and gap_cycles into shadow registers. Later input changes have no effect until the next accepted start.
  - If repeat_cnt=0, go to DONE.
  - Otherwise go to SHIFT with bit index = PAT_W-1 and reps_left = repeat_cnt.
- Latency: start sampled at edge N; in the cycle after edge N, x = pattern[PAT_W-1], x_valid=1, frame_start=1 and busy=1.
- SHIFT: each cycle drives x = shadow[idx] with x_valid=1 and busy=1. frame_start=1 only when idx=PAT_W-1. idx decrements each cycle. When the bit at idx=0 is sent:
  - If reps_left=1, go to DONE.
  - Else if gap=0, decrement reps_left and return to SHIFT with idx=PAT_W-1, with no idle cycle between repetitions.
  - Else decrement reps_left and go to GAP with gap counter = gap_cycles.
- GAP: x=0, x_valid=0, frame_start=0, busy=1 for exactly gap_cycles cycles, then SHIFT with idx=PAT_W-1.
- DONE: one cycle with done=1, busy=0, x=0, x_valid=0; then IDLE. A start asserted during DONE is ignored; start is accepted in IDLE on the following edge at the earliest.
- Totals: a burst occupies PAT_W*R + gap*(R-1) cycles of busy, followed by 1 done cycle. R is at most 2^CNT_W-1, and counters must not wrap.
- start while busy or in DONE is ignored. No queuing, and shadow registers are unchanged.
- abort=1 at an edge in SHIFT or GAP: next state IDLE, all outputs 0, no done pulse. In IDLE or DONE, abort has no effect.
- Simultaneous start and abort in IDLE: abort is ignored and start is accepted.
- rst_n asserted mid-burst: outputs go to 0 immediately (asynchronously). After release, the block waits in IDLE for a new start.

Test Plan:
1. PAT_W=4, pattern=4'b1011, repeat=2, gap=0, 1-cycle start → x=1,0,1,1,1,0,1,1 on 8 consecutive cycles with x_valid=1; frame_start on cycles 1 and 5; done=1 on cycle 9; busy low from cycle 9.
2. pattern=4'b1011, repeat=2, gap=3 → 1,0,1,1 (valid), then 3 cycles with x_valid=0 and busy=1, then 1,0,1,1, then done; busy high for 11 cycles total.
3. repeat=0 with start → done=1 in the cycle after start; x_valid, frame_start and busy never assert.
4. pattern=4'b1100, repeat=3; pulse start again mid-burst and change pattern to 4'b0001 after acceptance → output is exactly 1100 three times, a single done pulse, and no second burst.
5. pattern=4'b1011, repeat=4; assert abort on the 6th bit → outputs go to 0 next cycle, no done pulse; a new start then works normally.
6. Drive rst_n=0 asynchronously mid-SHIFT, between clock edges → x, x_valid, busy and frame_start drop to 0 immediately. After release with no start, all outputs stay 0.
